// File: rtl/viterbi_decoder_k3.sv
// -----------------------------------------------------------------------------
// viterbi_decoder_k3
//
// Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code with
// generators 7 (G0=111) and 5 (G1=101). It accepts one code symbol per clock
// and emits one decoded bit per clock. It uses register-exchange survivors
// TB_DEPTH bits deep, so the decode latency is TB_DEPTH clocks.
//
// Encoder state s = {b1, b0}, where b1 is the most recent input bit.
// For input u the encoder emits c1 = u^b1^b0 and c0 = u^b0, and moves to {u, b1}.
//
// Ports:
//   clk             rising-edge system clock
//   reset           synchronous, active-high reset
//   encoded_signal  [1:0] received symbol, bit 1 = G0 output, bit 0 = G1 output
//   decoded_signal  registered decoded data bit
//   err_count       [15:0] saturating estimate of channel bit errors on the
//                   best path (present only when VITERBI_ERRCNT_EN is defined)
//
// Optional feature macro: VITERBI_ERRCNT_EN
// -----------------------------------------------------------------------------
module viterbi_decoder_k3 #(
    parameter int TB_DEPTH  = 8,
    parameter int METRIC_W  = 4,
    parameter int INIT_BIAS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  encoded_signal,
    output logic        decoded_signal
`ifdef VITERBI_ERRCNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam int                  CW      = METRIC_W + 1;
    localparam logic [METRIC_W-1:0] PM_MAX  = '1;
    localparam logic [METRIC_W-1:0] PM_BIAS = METRIC_W'(INIT_BIAS);

    logic [METRIC_W-1:0] pm        [4];
    logic [TB_DEPTH-1:0] surv      [4];

    logic [CW-1:0]       cand0     [4];
    logic [CW-1:0]       cand1     [4];
    logic [CW-1:0]       cand_sel  [4];
    logic                sel       [4];
    logic [CW-1:0]       diff      [4];
    logic [METRIC_W-1:0] pm_next   [4];
    logic [TB_DEPTH-1:0] surv_next [4];

    logic [CW-1:0]       min01;
    logic [CW-1:0]       min23;
    logic [CW-1:0]       min_cand;

    logic [METRIC_W-1:0] best_pm01;
    logic [METRIC_W-1:0] best_pm23;
    logic [1:0]          best01;
    logic [1:0]          best23;
    logic [1:0]          best;

    // Hamming distance between the received symbol and the encoder output for
    // the transition that leaves state p on input u. The result is the 2-bit
    // population count of the XOR.
    function automatic logic [1:0] branch_metric(input logic [1:0] sym,
                                                 input logic [1:0] p,
                                                 input logic       u);
        logic [1:0] d;
        d = sym ^ {u ^ p[1] ^ p[0], u ^ p[0]};
        return {d[1] & d[0], d[1] ^ d[0]};
    endfunction

    // Add-compare-select for each next state n = {u, x}. Both predecessors,
    // {x,0} and {x,1}, share x as their most recent bit. Candidates carry one
    // extra bit so that pm + 2 cannot wrap. On a tie the even predecessor wins.
    for (genvar n = 0; n < 4; n++) begin : g_acs
        localparam logic [1:0] P0 = 2'((n % 2) * 2);
        localparam logic [1:0] P1 = P0 | 2'b01;
        localparam logic       U  = (n >= 2);

        assign cand0[n]    = CW'(pm[P0]) + CW'(branch_metric(encoded_signal, P0, U));
        assign cand1[n]    = CW'(pm[P1]) + CW'(branch_metric(encoded_signal, P1, U));
        assign sel[n]      = (cand1[n] < cand0[n]);
        assign cand_sel[n] = sel[n] ? cand1[n] : cand0[n];

        // After normalisation the best state sits at 0. Saturating the
        // distant states keeps them ranked as worst without letting them wrap.
        assign diff[n]     = cand_sel[n] - min_cand;
        assign pm_next[n]  = (diff[n] > CW'(PM_MAX)) ? PM_MAX : diff[n][METRIC_W-1:0];

        assign surv_next[n] = sel[n] ? {surv[P1][TB_DEPTH-2:0], U}
                                     : {surv[P0][TB_DEPTH-2:0], U};
    end

    // Smallest selected candidate. It normalises the metrics and is the
    // per-symbol error increment along the best path.
    always_comb begin
        min01    = (cand_sel[1] < cand_sel[0]) ? cand_sel[1] : cand_sel[0];
        min23    = (cand_sel[3] < cand_sel[2]) ? cand_sel[3] : cand_sel[2];
        min_cand = (min23 < min01) ? min23 : min01;
    end

    // Best state from the metrics held before the edge. Strict compares make
    // ties fall to the lowest index.
    always_comb begin
        best01    = (pm[1] < pm[0]) ? 2'd1 : 2'd0;
        best_pm01 = (pm[1] < pm[0]) ? pm[1] : pm[0];
        best23    = (pm[3] < pm[2]) ? 2'd3 : 2'd2;
        best_pm23 = (pm[3] < pm[2]) ? pm[3] : pm[2];
        best      = (best_pm23 < best_pm01) ? best23 : best01;
    end

    // Metric and survivor state. Reset biases the decoder toward the
    // all-zero starting state of the encoder.
    always_ff @(posedge clk) begin
        if (reset) begin
            pm[0]          <= '0;
            pm[1]          <= PM_BIAS;
            pm[2]          <= PM_BIAS;
            pm[3]          <= PM_BIAS;
            surv[0]        <= '0;
            surv[1]        <= '0;
            surv[2]        <= '0;
            surv[3]        <= '0;
            decoded_signal <= 1'b0;
        end else begin
            pm             <= pm_next;
            surv           <= surv_next;
            decoded_signal <= surv[best][TB_DEPTH-1];
        end
    end

`ifdef VITERBI_ERRCNT_EN
    logic [16:0] err_sum;

    assign err_sum = {1'b0, err_count} + 17'(min_cand);

    // Accumulate the best-path metric growth and hold at full scale.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count <= '0;
        end else begin
            err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// -----------------------------------------------------------------------------
// tb_viterbi_decoder_k3
//
// Self-checking bench for viterbi_decoder_k3. It runs three instances with
// TB_DEPTH = 4, 8 and 16 from the same symbol stream. Each message bit goes
// into a per-instance queue that is preloaded with TB_DEPTH zeros after reset.
// One entry is popped per clock and compared with that instance's output.
// When VITERBI_ERRCNT_EN is defined, err_count is also checked.
// -----------------------------------------------------------------------------
module tb_viterbi_decoder_k3;

    logic       clk;
    logic       reset;
    logic [1:0] encoded_signal;
    logic       dec4;
    logic       dec8;
    logic       dec16;
`ifdef VITERBI_ERRCNT_EN
    logic [15:0] err4;
    logic [15:0] err8;
    logic [15:0] err16;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bit q4[$];
    bit q8[$];
    bit q16[$];

    // Table record: whether the 1,0,1,1,0,0 message is sent, up to two
    // injected symbol errors (index -1 = none), and the expected error count.
    typedef struct {
        bit         msg_on;
        int         flip_a;
        logic [1:0] mask_a;
        int         flip_b;
        logic [1:0] mask_b;
        int         exp_err;
    } vec_t;

    vec_t       vecs [4];
    logic [1:0] base_syms [6];
    bit         base_msg  [6];

    viterbi_decoder_k3 #(.TB_DEPTH(4), .METRIC_W(4), .INIT_BIAS(4)) dut4 (
        .clk            (clk),
        .reset          (reset),
        .encoded_signal (encoded_signal),
        .decoded_signal (dec4)
`ifdef VITERBI_ERRCNT_EN
        ,
        .err_count      (err4)
`endif
    );

    viterbi_decoder_k3 dut8 (
        .clk            (clk),
        .reset          (reset),
        .encoded_signal (encoded_signal),
        .decoded_signal (dec8)
`ifdef VITERBI_ERRCNT_EN
        ,
        .err_count      (err8)
`endif
    );

    viterbi_decoder_k3 #(.TB_DEPTH(16), .METRIC_W(4), .INIT_BIAS(4)) dut16 (
        .clk            (clk),
        .reset          (reset),
        .encoded_signal (encoded_signal),
        .decoded_signal (dec16)
`ifdef VITERBI_ERRCNT_EN
        ,
        .err_count      (err16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time guard so that the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic clearQueues();
        q4.delete();
        q8.delete();
        q16.delete();
        repeat (4)  q4.push_back(1'b0);
        repeat (8)  q8.push_back(1'b0);
        repeat (16) q16.push_back(1'b0);
    endtask

    // Hold reset for the given number of edges with junk on the input.
    // Outputs must read zero after every reset edge.
    task automatic doReset(input int cycles);
        @(negedge clk);
        reset          = 1'b1;
        encoded_signal = 2'($urandom_range(0, 3));
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("reset edge %0d dec8", c), 32'(dec8), 32'd0);
`ifdef VITERBI_ERRCNT_EN
            checkOutput($sformatf("reset edge %0d err8", c), 32'(err8), 32'd0);
`endif
        end
        @(negedge clk);
        reset = 1'b0;
        clearQueues();
    endtask

    // Drive one symbol and push the message bit it carries. After the edge,
    // pop the expected output of each instance and compare it.
    task automatic applyStimulus(input logic [1:0] sym, input bit msg_bit,
                                 input bit check_all, input string tag);
        bit e4;
        bit e8;
        bit e16;
        @(negedge clk);
        encoded_signal = sym;
        q4.push_back(msg_bit);
        q8.push_back(msg_bit);
        q16.push_back(msg_bit);
        @(posedge clk);
        #1;
        e4  = q4.pop_front();
        e8  = q8.pop_front();
        e16 = q16.pop_front();
        checkOutput({tag, " dec8"}, 32'(dec8), 32'(e8));
        if (check_all) begin
            checkOutput({tag, " dec4"}, 32'(dec4), 32'(e4));
            checkOutput({tag, " dec16"}, 32'(dec16), 32'(e16));
        end
    endtask

    initial begin
        logic [1:0] sym;
        bit         mbit;
        logic [1:0] enc_state;
        bit         u;

        base_syms = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd1, 2'd3};
        base_msg  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        vecs[0] = '{msg_on: 1'b0, flip_a: -1, mask_a: 2'b00, flip_b: -1, mask_b: 2'b00, exp_err: 0};
        vecs[1] = '{msg_on: 1'b1, flip_a: -1, mask_a: 2'b00, flip_b: -1, mask_b: 2'b00, exp_err: 0};
        vecs[2] = '{msg_on: 1'b1, flip_a:  2, mask_a: 2'b10, flip_b: -1, mask_b: 2'b00, exp_err: 1};
        vecs[3] = '{msg_on: 1'b1, flip_a:  1, mask_a: 2'b01, flip_b: 10, mask_b: 2'b01, exp_err: 2};

        reset          = 1'b1;
        encoded_signal = 2'd0;

        // Table-driven streams: all zeros, the clean message, and two noisy
        // versions of the message.
        for (int t = 0; t < 4; t++) begin
            doReset(2);
            for (int k = 0; k < 40; k++) begin
                sym  = (vecs[t].msg_on && k < 6) ? base_syms[k] : 2'd0;
                mbit = (vecs[t].msg_on && k < 6) ? base_msg[k]  : 1'b0;
                if (k == vecs[t].flip_a) sym = sym ^ vecs[t].mask_a;
                if (k == vecs[t].flip_b) sym = sym ^ vecs[t].mask_b;
                applyStimulus(sym, mbit, 1'b0, $sformatf("vec %0d sym %0d", t, k));
            end
`ifdef VITERBI_ERRCNT_EN
            checkOutput($sformatf("vec %0d err8", t), 32'(err8), 32'(vecs[t].exp_err));
`endif
            $display("[TB] vector %0d done (expected error estimate %0d)", t, vecs[t].exp_err);
        end

        // Reset mid-stream. Edge 8 leaves the first message bit (1) on the
        // output, then one reset clock must clear all history.
        doReset(1);
        for (int k = 0; k < 9; k++) begin
            applyStimulus(base_syms[k % 6], (k < 6) ? base_msg[k % 6] : 1'b0, 1'b0,
                          $sformatf("pre-reset sym %0d", k));
        end
        doReset(1);
        for (int k = 0; k < 20; k++) begin
            sym  = (k < 6) ? base_syms[k] : 2'd0;
            mbit = (k < 6) ? base_msg[k]  : 1'b0;
            applyStimulus(sym, mbit, 1'b0, $sformatf("post-reset sym %0d", k));
        end

        // Noiseless random message through a bench-side encoder. All three
        // depths must reproduce it at their own latency.
        doReset(2);
        enc_state = 2'b00;
        for (int k = 0; k < 1000; k++) begin
            u         = 1'($urandom_range(0, 1));
            sym       = {u ^ enc_state[1] ^ enc_state[0], u ^ enc_state[0]};
            enc_state = {u, enc_state[1]};
            applyStimulus(sym, u, 1'b1, $sformatf("random sym %0d", k));
        end
`ifdef VITERBI_ERRCNT_EN
        checkOutput("random err4", 32'(err4), 32'd0);
        checkOutput("random err8", 32'(err8), 32'd0);
        checkOutput("random err16", 32'(err16), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
